// File: rtl/midi_voice_allocator_if.sv
// Event and voice-bank signal bundle for the polyphonic voice allocator.
// The master side is the upstream parser and voice bank; the slave side is the allocator.
interface midi_voice_allocator_if #(
    parameter int NUM_VOICES = 8
);
    localparam int VIDX_W = $clog2(NUM_VOICES);

    logic                  i_evt_valid;
    logic                  o_evt_ready;
    logic                  i_evt_on;
    logic [6:0]            i_evt_note;
    logic [6:0]            i_evt_vel;
    logic                  i_panic;
    logic                  o_voice_wr;
    logic [VIDX_W-1:0]     o_voice_idx;
    logic [6:0]            o_voice_note;
    logic [6:0]            o_voice_vel;
    logic                  o_voice_gate;
    logic                  o_steal;
    logic [NUM_VOICES-1:0] o_active_mask;

    modport master (
        output i_evt_valid, i_evt_on, i_evt_note, i_evt_vel, i_panic,
        input  o_evt_ready, o_voice_wr, o_voice_idx, o_voice_note, o_voice_vel,
               o_voice_gate, o_steal, o_active_mask
    );

    modport slave (
        input  i_evt_valid, i_evt_on, i_evt_note, i_evt_vel, i_panic,
        output o_evt_ready, o_voice_wr, o_voice_idx, o_voice_note, o_voice_vel,
               o_voice_gate, o_steal, o_active_mask
    );
endinterface

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice scheduler: serially scans the voice table per event and issues one
// configuration write (retrigger > free voice > steal oldest), plus an all-notes-off sweep.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    midi_voice_allocator_if.slave  bus
);
    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, PANIC} state_t;

    state_t state, state_nxt;

    logic [NUM_VOICES-1:0] active;
    logic [6:0]            note_tab [NUM_VOICES];
    logic [AGE_W-1:0]      age_tab  [NUM_VOICES];

    logic              lat_on;
    logic [6:0]        lat_note;
    logic [6:0]        lat_vel;
    logic [VIDX_W-1:0] scan_idx;
    logic [VIDX_W-1:0] pan_idx;
    logic              match_found, free_found, old_found;
    logic [VIDX_W-1:0] match_idx, free_idx, old_idx;
    logic [AGE_W-1:0]  old_age;

    logic              voice_wr, voice_gate, steal;
    logic [VIDX_W-1:0] voice_idx;
    logic [6:0]        voice_note, voice_vel;

    logic              do_write;
    logic              steal_c;
    logic [VIDX_W-1:0] tgt_idx;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    wire accept = (state == IDLE) && bus.i_evt_valid && !bus.i_panic;

    assign bus.o_evt_ready   = (state == IDLE) && !bus.i_panic;
    assign bus.o_voice_wr    = voice_wr;
    assign bus.o_voice_idx   = voice_idx;
    assign bus.o_voice_note  = voice_note;
    assign bus.o_voice_vel   = voice_vel;
    assign bus.o_voice_gate  = voice_gate;
    assign bus.o_steal       = steal;
    assign bus.o_active_mask = active;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.i_panic) begin
            state_nxt = PANIC;
        end else begin
            case (state)
                IDLE:    if (bus.i_evt_valid) state_nxt = SCAN;
                SCAN:    if (scan_idx == LAST_IDX) state_nxt = WRITE;
                WRITE:   state_nxt = IDLE;
                PANIC:   if (pan_idx == LAST_IDX) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Target resolution from the candidates gathered during the scan
    always_comb begin
        do_write = 1'b0;
        steal_c  = 1'b0;
        tgt_idx  = match_idx;
        if (lat_on) begin
            do_write = 1'b1;
            if (match_found) begin
                tgt_idx = match_idx;
            end else if (free_found) begin
                tgt_idx = free_idx;
            end else begin
                tgt_idx = old_idx;
                steal_c = 1'b1;
            end
        end else if (match_found) begin
            do_write = 1'b1;
        end
    end

    // Event latch and scan candidates; reinitialised on every acceptance
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lat_on      <= bus.i_evt_on && (bus.i_evt_vel != 7'd0);
            lat_note    <= bus.i_evt_note;
            lat_vel     <= bus.i_evt_vel;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            old_found   <= 1'b0;
            match_idx   <= '0;
            free_idx    <= '0;
            old_idx     <= '0;
            old_age     <= '0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (active[scan_idx]) begin
                if (!match_found && note_tab[scan_idx] == lat_note) begin
                    match_found <= 1'b1;
                    match_idx   <= scan_idx;
                end
                if (!old_found || age_tab[scan_idx] > old_age) begin
                    old_found <= 1'b1;
                    old_age   <= age_tab[scan_idx];
                    old_idx   <= scan_idx;
                end
            end else if (!free_found) begin
                free_found <= 1'b1;
                free_idx   <= scan_idx;
            end
        end
        if (bus.i_panic)         pan_idx <= VIDX_W'(1);
        else if (state == PANIC) pan_idx <= pan_idx + 1'b1;
    end

    // Voice table and registered write port
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            active     <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_tab[v] <= '0;
                age_tab[v]  <= '0;
            end
            voice_wr   <= 1'b0;
            voice_idx  <= '0;
            voice_note <= '0;
            voice_vel  <= '0;
            voice_gate <= 1'b0;
            steal      <= 1'b0;
        end else begin
            voice_wr <= 1'b0;
            steal    <= 1'b0;
            if (bus.i_panic) begin
                active <= '0;
                for (int v = 0; v < NUM_VOICES; v++) age_tab[v] <= '0;
                voice_wr   <= 1'b1;
                voice_idx  <= '0;
                voice_note <= '0;
                voice_vel  <= '0;
                voice_gate <= 1'b0;
            end else if (state == PANIC) begin
                voice_wr   <= 1'b1;
                voice_idx  <= pan_idx;
                voice_note <= '0;
                voice_vel  <= '0;
                voice_gate <= 1'b0;
            end else if (state == WRITE && do_write) begin
                voice_wr   <= 1'b1;
                voice_idx  <= tgt_idx;
                voice_gate <= lat_on;
                steal      <= steal_c;
                if (lat_on) begin
                    voice_note        <= lat_note;
                    voice_vel         <= lat_vel;
                    active[tgt_idx]   <= 1'b1;
                    note_tab[tgt_idx] <= lat_note;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (VIDX_W'(v) == tgt_idx) age_tab[v] <= '0;
                        else if (active[v])        age_tab[v] <= age_inc(age_tab[v]);
                    end
                end else begin
                    voice_note      <= note_tab[tgt_idx];
                    voice_vel       <= '0;
                    active[tgt_idx] <= 1'b0;
                end
            end
        end
    end
endmodule
